// File: rtl/lsu_dmem_master_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// debug view and the alignment/legality helpers used at request accept.
package lsu_pkg;

    // RV32I funct3 width/sign codes (loads and stores share 000/001/010)
    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_e;

    // Debug view: FSM state plus a flag for addresses whose upper bits the
    // memory ignores (the access aliases onto a lower word).
    typedef struct packed {
        lsu_state_e state;
        logic       addr_alias;
    } lsu_dbg_t;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Loads accept B/H/W/BU/HU; stores have no unsigned forms.
    function automatic logic is_illegal(input logic [2:0] funct3,
                                        input logic       write);
        logic ill;
        ill = 1'b1;
        case (funct3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = write;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/lsu_dmem_master_if.sv
// Bus bundle between the pipeline/memory environment and the load/store unit.
//
// Handshake rules: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on an edge where resp_valid and
// resp_ready are both 1. While valid is high and ready is low, the payload
// (req_* from the pipeline, resp_rdata/resp_err from the unit) is held stable.
// Memory side: out_mem_read qualifies a combinational read of in_mem_rdata at
// word index out_mem_addr; out_mem_write is a single-cycle write strobe.
interface lsu_dmem_master_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [31:0]       out_mem_addr;
    logic [31:0]       out_mem_data;
    logic              out_mem_write;
    logic              out_mem_read;
    logic [31:0]       in_mem_rdata;

    // The load/store unit
    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output out_mem_addr, out_mem_data, out_mem_write, out_mem_read,
        input  in_mem_rdata
    );

    // The pipeline and data memory around it
    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  out_mem_addr, out_mem_data, out_mem_write, out_mem_read,
        output in_mem_rdata
    );
endinterface

// File: rtl/lsu_dmem_master_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of a memory word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane selection: byte lane k is bits [8k+7:8k], halfword by addr[1]
    always_comb begin
        lane_b = word[7:0];
        case (addr_lo)
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            2'd3:    lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Extension by access type; illegal codes yield zero (never reached)
    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'b0, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'b0, lane_h};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// MEM-stage load/store unit driving a word-organised data memory. One
// transaction at a time: loads read one word, SW writes one word, SB/SH do a
// read-modify-write; misaligned or illegal requests answer with an error and
// never touch memory.
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_IDX_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    lsu_dmem_master_if.master bus,
    output lsu_dbg_t          dbg
);

    lsu_state_e        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              write_q,  write_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [31:0]       word_q,   word_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic              err_q,    err_d;

    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [31:0] word_idx;

    assign word_idx = 32'(addr_q >> 2);
    assign req_err  = is_misaligned(bus.req_funct3, bus.req_addr[1:0])
                    | is_illegal(bus.req_funct3, bus.req_write);

    lsu_load_align u_load_align (
        .word    (bus.in_mem_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .data    (load_data)
    );

    // Store merge: SW replaces the word, SB/SH patch lanes of the read word
    always_comb begin
        store_data = word_q;
        case (funct3_q)
            F3_W: store_data = wdata_q;
            F3_H: begin
                if (addr_q[1]) store_data[31:16] = wdata_q[15:0];
                else           store_data[15:0]  = wdata_q[15:0];
            end
            F3_B: begin
                case (addr_q[1:0])
                    2'd0:    store_data[7:0]   = wdata_q[7:0];
                    2'd1:    store_data[15:8]  = wdata_q[7:0];
                    2'd2:    store_data[23:16] = wdata_q[7:0];
                    default: store_data[31:24] = wdata_q[7:0];
                endcase
            end
            default: store_data = word_q;
        endcase
    end

    // Next-state and latched-register updates
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    funct3_d = bus.req_funct3;
                    write_d  = bus.req_write;
                    wdata_d  = bus.req_wdata;
                    word_d   = '0;
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err)                     state_d = ST_RESP;
                    else if (!bus.req_write)         state_d = ST_READ;
                    else if (bus.req_funct3 == F3_W) state_d = ST_WRITE;
                    else                             state_d = ST_RMW_READ;
                end
            end
            ST_READ: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_RMW_READ: begin
                word_d  = bus.in_mem_rdata;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Bus outputs decoded from state; write strobe is killed by reset
    always_comb begin
        bus.req_ready     = (state_q == ST_IDLE);
        bus.resp_valid    = (state_q == ST_RESP);
        bus.resp_rdata    = rdata_q;
        bus.resp_err      = err_q;
        bus.out_mem_addr  = '0;
        bus.out_mem_data  = '0;
        bus.out_mem_read  = 1'b0;
        bus.out_mem_write = 1'b0;
        case (state_q)
            ST_READ, ST_RMW_READ: begin
                bus.out_mem_addr = word_idx;
                bus.out_mem_read = 1'b1;
            end
            ST_WRITE: begin
                bus.out_mem_addr  = word_idx;
                bus.out_mem_data  = store_data;
                bus.out_mem_write = !reset;
            end
            default: ;
        endcase
    end

    // Debug view; write_q only steers the FSM so it is shown via state
    always_comb begin
        dbg.state      = state_q;
        dbg.addr_alias = |(addr_q >> (MEM_IDX_W + 2)) & (write_q | !write_q);
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: directed scenarios followed by random traffic,
// checked against a byte-addressed reference memory and latency table.
module tb_lsu_dmem_master;
    import lsu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_dmem_master_if #(.ADDR_W(32)) bus ();
    lsu_dbg_t dbg;

    lsu_dmem_master #(.ADDR_W(32), .MEM_IDX_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .dbg   (dbg)
    );

    // ---------------- data memory (1024 words) ----------------
    logic [31:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_val;

    assign bus.in_mem_rdata = mem[bus.out_mem_addr[9:0]];

    always @(posedge clk) begin
        if (bus.out_mem_write) mem[bus.out_mem_addr[9:0]] <= bus.out_mem_data;
        else if (pl_en)        mem[pl_idx] <= pl_val;
    end

    // ---------------- reference model: byte-addressed memory ----------------
    logic [7:0] ref_mem [0:4095];

    int cmp_cnt  = 0;
    int mism_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mism_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic exp_err(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        return (int'(addr[1:0]) % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_word(input int widx);
        return {ref_mem[widx*4+3], ref_mem[widx*4+2], ref_mem[widx*4+1], ref_mem[widx*4]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        int base;
        logic [31:0] v;
        n = size_of(f3);
        base = int'(addr[11:0]);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int base;
        base = int'(addr[11:0]);
        for (int i = 0; i < size_of(f3); i++) ref_mem[base + i] = 8'(wd >> (8 * i));
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input int idx, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_idx = 10'(idx);
        pl_val = val;
        for (int i = 0; i < 4; i++) ref_mem[idx*4 + i] = 8'(val >> (8 * i));
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one request, follow it to its response, stall the response for
    // 'stall' cycles (with a competing request pending), then release it.
    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int stall);
        logic        e_err;
        logic [31:0] e_rdata, e_word, e_widx;
        int          e_lat, e_rd, e_wr;
        int          cyc, n_rd, n_wr, first_rd;
        logic [31:0] rd_addr, wr_addr, wr_data;

        e_err  = exp_err(wr, f3, addr);
        e_widx = {2'b00, addr[31:2]};
        e_word = '0;
        e_rdata = '0;
        if (e_err) begin
            e_lat = 1; e_rd = 0; e_wr = 0;
        end else if (!wr) begin
            e_lat = 2; e_rd = 1; e_wr = 0;
            e_rdata = ref_load(f3, addr);
        end else begin
            e_lat = (f3 == F3_W) ? 2 : 3;
            e_rd  = (f3 == F3_W) ? 0 : 1;
            e_wr  = 1;
            ref_store(f3, addr, wd);
            e_word = ref_word(int'(addr[11:2]));
        end

        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;

        cyc = 1; n_rd = 0; n_wr = 0; first_rd = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        while (!bus.resp_valid && cyc < 10) begin
            if (bus.out_mem_read) begin
                n_rd++;
                rd_addr = bus.out_mem_addr;
                if (first_rd == 0) first_rd = cyc;
            end
            if (bus.out_mem_write) begin
                n_wr++;
                wr_addr = bus.out_mem_addr;
                wr_data = bus.out_mem_data;
            end
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end

        check("latency", 32'(cyc), 32'(e_lat));
        check("resp_valid", 32'(bus.resp_valid), 32'd1);
        check("resp_rdata", bus.resp_rdata, e_rdata);
        check("resp_err", 32'(bus.resp_err), 32'(e_err));
        check("read_pulses", 32'(n_rd), 32'(e_rd));
        check("write_pulses", 32'(n_wr), 32'(e_wr));
        check("resp_strobes", {30'b0, bus.out_mem_read, bus.out_mem_write}, 32'd0);
        check("resp_mem_addr", bus.out_mem_addr, 32'd0);
        check("addr_alias", 32'(dbg.addr_alias), 32'(addr[31:12] != 20'd0));
        if (e_rd != 0) begin
            check("read_addr", rd_addr, e_widx);
            check("read_cycle", 32'(first_rd), 32'd1);
        end
        if (e_wr != 0) begin
            check("write_addr", wr_addr, e_widx);
            check("write_data", wr_data, e_word);
        end

        for (int k = 0; k < stall; k++) begin
            bus.req_valid  = 1'b1;
            bus.req_write  = 1'b1;
            bus.req_funct3 = F3_W;
            bus.req_addr   = 32'h40;
            bus.req_wdata  = 32'hFFFF_FFFF;
            check("stall_valid", 32'(bus.resp_valid), 32'd1);
            check("stall_rdata", bus.resp_rdata, e_rdata);
            check("stall_err", 32'(bus.resp_err), 32'(e_err));
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end

        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        check("release_valid", 32'(bus.resp_valid), 32'd0);
        check("release_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic        r_wr;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        logic [2:0]  f3_tab [0:7];

        f3_tab[0] = F3_B;  f3_tab[1] = F3_H;  f3_tab[2] = F3_W;  f3_tab[3] = F3_BU;
        f3_tab[4] = F3_HU; f3_tab[5] = F3_W;  f3_tab[6] = 3'b011; f3_tab[7] = 3'b110;

        reset          = 1'b1;
        pl_en          = 1'b0;
        pl_idx         = '0;
        pl_val         = '0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;

        for (int i = 0; i < 1024; i++) preload(i, $urandom);
        reset = 1'b0;

        // Reset state and idle outputs
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_addr", bus.out_mem_addr, 32'd0);
        check("rst_mem_data", bus.out_mem_data, 32'd0);
        check("rst_strobes", {30'b0, bus.out_mem_read, bus.out_mem_write}, 32'd0);
        check("rst_state", 32'(dbg.state), 32'(ST_IDLE));

        // Word load
        preload(4, 32'hDEAD_BEEF);
        run_txn(1'b0, F3_W, 32'h10, 32'h0, 0);

        // Byte / halfword loads with sign and zero extension
        preload(4, 32'h80FF_1234);
        run_txn(1'b0, F3_B,  32'h13, 32'h0, 0);
        run_txn(1'b0, F3_BU, 32'h13, 32'h0, 0);
        run_txn(1'b0, F3_H,  32'h12, 32'h0, 0);
        check("lb_const", ref_load(F3_B, 32'h13), 32'hFFFF_FF80);

        // Byte store via read-modify-write
        preload(4, 32'h1122_3344);
        run_txn(1'b1, F3_B, 32'h11, 32'h0000_00AA, 0);
        check("sb_mem_word", mem[4], 32'h1122_AA44);

        // Error cases: misaligned LW, misaligned SH, illegal funct3
        run_txn(1'b0, F3_W, 32'h12, 32'h0, 0);
        run_txn(1'b1, F3_H, 32'h13, 32'h1234_5678, 0);
        run_txn(1'b0, 3'b011, 32'h20, 32'h0, 0);
        run_txn(1'b1, F3_BU, 32'h20, 32'h0, 0);

        // Response back-pressure with a competing request pending
        run_txn(1'b0, F3_W, 32'h10, 32'h0, 5);
        run_txn(1'b1, F3_H, 32'h22, 32'hCAFE_BABE, 0);

        // Reset landing in the WRITE cycle of an SW
        preload(8, 32'h0BAD_F00D);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("pre_reset_write", 32'(bus.out_mem_write), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_gates_write", 32'(bus.out_mem_write), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("post_reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        check("post_reset_resp_valid2", 32'(bus.resp_valid), 32'd0);
        check("post_reset_mem", mem[8], 32'h0BAD_F00D);

        // Random traffic, including upper address bits the memory ignores
        for (int t = 0; t < 80; t++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_f3   = f3_tab[$urandom_range(0, 7)];
            r_addr = $urandom;
            if (r_addr[31]) r_addr[31:12] = '0;
            if ($urandom_range(0, 3) != 0) begin
                if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
                if (r_f3[1:0] == 2'b10) r_addr[1:0] = 2'b00;
            end
            run_txn(r_wr, r_f3, r_addr, $urandom, $urandom_range(0, 3));
        end

        // Final memory sweep against the reference
        for (int i = 0; i < 1024; i++) check("final_mem", mem[i], ref_word(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store unit in the MEM stage. Initiator that drives the word-organised data memory.
- Turns RV32I byte, halfword and word loads/stores from the pipeline into word reads, word writes, or read-modify-write sequences.
- Loads: extracts the addressed bytes and sign- or zero-extends them.
- Flags misaligned accesses and illegal funct3 values; these never touch memory.

Parameters:
- ADDR_W, 32, byte-address width from the pipeline.
- MEM_IDX_W, 10, word-index bits consumed by the memory.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  pipeline request valid
- req_ready  out  1  unit can accept a request
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV32I width/sign field
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; low bytes used for SB/SH
- resp_valid  out  1  response valid
- resp_ready  in  1  pipeline accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned or illegal funct3
- out_mem_addr  out  32  word index: {2'b0, addr[31:2]}
- out_mem_data  out  32  write data to memory
- out_mem_write  out  1  write strobe, one cycle
- out_mem_read  out  1  read qualifier
- in_mem_rdata  in  32  combinational read data from memory

Behaviour:
- Shared package constants (funct3): LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101. All other codes are illegal; for stores, 100 and 101 are also illegal.
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- Request latching: in IDLE, req_ready=1. When req_valid && req_ready, latch addr, funct3, write, wdata.
- Transitions out of IDLE:
  - error (misaligned or illegal funct3) -> RESP, with resp_err=1
  - load -> READ
  - SW -> WRITE
  - SB/SH -> RMW_READ
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- READ: out_mem_read=1 with the latched word index. At the next edge, capture the extracted and extended data -> RESP.
  - Byte lane = addr[1:0]: lane k is bits [8k+7:8k].
  - Halfword = addr[1] ? [31:16] : [15:0].
- RMW_READ: out_mem_read=1. At the next edge, capture in_mem_rdata -> WRITE.
- WRITE: out_mem_write=1 for exactly one cycle.
  - out_mem_data = wdata for SW.
  - Otherwise, out_mem_data = the captured word with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Next state is RESP.
- RESP: resp_valid=1; hold resp_rdata and resp_err stable until resp_ready. Go to IDLE on the edge where resp_ready=1. req_ready=0 in every state except IDLE.
- Latency from the accept edge to resp_valid:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 1 cycle
- The response is not combinationally dependent on req_*. Only one transaction is in flight at a time.
- Idle outputs: out_mem_addr=0, out_mem_data=0, and all strobes low.
- Reset:
  - state=IDLE; all latched registers 0.
  - resp_valid=0, resp_rdata=0, resp_err=0, out_mem_write=0, out_mem_read=0.
  - out_mem_write is additionally gated by !reset, so reset asserted during WRITE produces no memory write.
  - A transaction interrupted by reset is discarded and produces no response.
- Simultaneous req_valid with resp_valid: the request is not accepted until IDLE (req_ready=0).
- Address wrap: upper bits beyond MEM_IDX_W+2 are passed through. The memory ignores them; the unit does not check range.

Decomposition:
- Package lsu_pkg: funct3 localparams, state enum typedef, is_misaligned() function.
- One natural sub-module, lsu_load_align: combinational lane select plus sign/zero extension from (word, addr[1:0], funct3).
- The store merge stays inline.

Test Plan:
- Reset, then LW at 0x10 with mem word 4 = 0xDEADBEEF:
  - out_mem_read high with addr=4 in the cycle after accept.
  - resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF, resp_err=0.
- LB/LBU at 0x13 with word 4 = 0x80FF1234:
  - LB -> 0xFFFFFF80
  - LBU -> 0x00000080
  - LH at 0x12 -> 0xFFFF80FF
- SB wdata=0xAA at 0x11 with word 4 = 0x11223344:
  - one out_mem_write with data=0x1122AA44, addr=4.
  - resp_valid 3 cycles after accept.
- Misaligned LW at 0x12, SH at 0x13, and illegal funct3 011:
  - resp_err=1 after 1 cycle.
  - no out_mem_read or out_mem_write pulse.
- Back-pressure: resp_ready held 0 for 5 cycles:
  - resp_valid, resp_rdata and resp_err stable; req_ready=0.
  - A new req_valid is accepted only in the cycle after resp_ready=1.
- Reset asserted in WRITE of an SW:
  - no write pulse; memory word unchanged; no resp_valid.
  - req_ready=1 the cycle after reset deasserts.
